id_ex_stage_reg: RTL and testbench

- ID→EX pipeline register for the pipelined RV32I core.
- Sits directly downstream of the control unit. It captures the decoded control bundle and the operands each cycle.
- Contains the load-use hazard detector. It inserts bubbles on hazards and flushes on redirects from EX.
- Keeps a bubble performance counter.

---
 rtl/rv32i_pkg.sv | 45 ++++
 rtl/hazard_detect.sv | 26 ++
 rtl/id_ex_stage_reg.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcodes, one-hot control indices and the decoded control bundle
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;

    localparam int LD_LB  = 0;
    localparam int LD_LH  = 1;
    localparam int LD_LW  = 2;
    localparam int LD_LBU = 3;
    localparam int LD_LHU = 4;

    localparam int ST_SB = 0;
    localparam int ST_SH = 1;
    localparam int ST_SW = 2;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       jump;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic [5:0] branch;
        logic [4:0] load;
        logic [2:0] store;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_ZERO = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - operand-use decode and load-use compare against the EX-stage load
module hazard_detect
    import rv32i_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [6:0] id_op_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       ex_valid_i,
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_rd_i,
    output logic       load_use_o
);

    logic use_rs1;
    logic use_rs2;

    always_comb begin
        use_rs1 = !((id_op_i == OP_LUI) || (id_op_i == OP_AUIPC) || (id_op_i == OP_JAL));
        use_rs2 = (id_op_i == OP_R) || (id_op_i == OP_STORE) || (id_op_i == OP_BRANCH);
        // x0 is never a real producer, so a load to x0 cannot create a dependency
        load_use_o = id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                     ((use_rs1 & (id_rs1_i == ex_rd_i)) | (use_rs2 & (id_rs2_i == ex_rd_i)));
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID->EX pipeline register with load-use bubbles, flush and bubble counter
module id_ex_stage_reg
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_op,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_pc_plus4,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_jump,
    input  logic [1:0]       id_result_src,
    input  logic [3:0]       id_alu_control,
    input  logic [5:0]       id_branch,
    input  logic [4:0]       id_load,
    input  logic [2:0]       id_store,
    input  logic             ex_stall,
    input  logic             ex_flush,
    output logic             ex_valid,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_pc_plus4,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic             ex_reg_write,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_jump,
    output logic [1:0]       ex_result_src,
    output logic [3:0]       ex_alu_control,
    output logic [5:0]       ex_branch,
    output logic [4:0]       ex_load,
    output logic [2:0]       ex_store,
    output logic             id_hold,
    output logic [CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
    } data_t;

    logic         valid_d, valid_q;
    ctrl_bundle_t ctrl_d, ctrl_q;
    data_t        data_d, data_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    ctrl_bundle_t id_ctrl;
    data_t        id_data;
    logic         load_use;

    hazard_detect u_hazard_detect (
        .id_valid_i   (id_valid),
        .id_op_i      (id_op),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .ex_valid_i   (valid_q),
        .ex_is_load_i (|ctrl_q.load),
        .ex_rd_i      (data_q.rd),
        .load_use_o   (load_use)
    );

    // a flush squashes the ID instruction anyway, so holding IF/ID for the hazard is pointless
    assign id_hold = ex_stall | (load_use & ~ex_flush);

    always_comb begin
        id_ctrl.reg_write   = id_reg_write;
        id_ctrl.mem_write   = id_mem_write;
        id_ctrl.alu_src     = id_alu_src;
        id_ctrl.jump        = id_jump;
        id_ctrl.result_src  = id_result_src;
        id_ctrl.alu_control = id_alu_control;
        id_ctrl.branch      = id_branch;
        id_ctrl.load        = id_load;
        id_ctrl.store       = id_store;

        id_data.rs1      = id_rs1;
        id_data.rs2      = id_rs2;
        id_data.rd       = id_rd;
        id_data.pc       = id_pc;
        id_data.pc_plus4 = id_pc_plus4;
        id_data.rd1      = id_rd1;
        id_data.rd2      = id_rd2;
        id_data.imm      = id_imm;
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (ex_flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_ZERO;
            data_d  = '0;
        end else if (ex_stall) begin
            valid_d = valid_q;
        end else if (load_use) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_ZERO;
            data_d  = '0;
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            // invalid slots must not carry side-effecting control into EX
            valid_d = id_valid;
            ctrl_d  = id_valid ? id_ctrl : CTRL_ZERO;
            data_d  = id_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_ZERO;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_rs1         = data_q.rs1;
    assign ex_rs2         = data_q.rs2;
    assign ex_rd          = data_q.rd;
    assign ex_pc          = data_q.pc;
    assign ex_pc_plus4    = data_q.pc_plus4;
    assign ex_rd1         = data_q.rd1;
    assign ex_rd2         = data_q.rd2;
    assign ex_imm         = data_q.imm;
    assign ex_reg_write   = ctrl_q.reg_write;
    assign ex_mem_write   = ctrl_q.mem_write;
    assign ex_alu_src     = ctrl_q.alu_src;
    assign ex_jump        = ctrl_q.jump;
    assign ex_result_src  = ctrl_q.result_src;
    assign ex_alu_control = ctrl_q.alu_control;
    assign ex_branch      = ctrl_q.branch;
    assign ex_load        = ctrl_q.load;
    assign ex_store       = ctrl_q.store;
    assign bubble_count   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - table-driven scoreboard bench for the ID->EX stage register
module tb_id_ex_stage_reg;
    import rv32i_pkg::*;

    typedef enum logic [1:0] {K_CAP, K_BUB, K_LUB, K_HOLD} kind_e;

    typedef struct {
        logic       v;
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       regw;
        logic [4:0] ld;
        logic [7:0] tag;
        logic       stall, flush, exp_hold;
        kind_e      kind;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pc4, rd1, rd2, imm;
        logic        regw, memw, alusrc, jump;
        logic [1:0]  rsrc;
        logic [3:0]  aluc;
        logic [5:0]  br;
        logic [4:0]  ld;
        logic [2:0]  st;
        logic [31:0] cnt;
    } snap_t;

    localparam logic [4:0] LW  = 5'b00100;
    localparam logic [4:0] LB  = 5'b00001;
    localparam logic [4:0] LHU = 5'b10000;

    logic clk = 1'b0;
    logic rst;
    logic id_valid;
    logic [6:0] id_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [31:0] id_pc, id_pc_plus4, id_rd1, id_rd2, id_imm;
    logic id_reg_write, id_mem_write, id_alu_src, id_jump;
    logic [1:0] id_result_src;
    logic [3:0] id_alu_control;
    logic [5:0] id_branch;
    logic [4:0] id_load;
    logic [2:0] id_store;
    logic ex_stall, ex_flush;
    logic ex_valid;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_pc, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
    logic ex_reg_write, ex_mem_write, ex_alu_src, ex_jump;
    logic [1:0] ex_result_src;
    logic [3:0] ex_alu_control;
    logic [5:0] ex_branch;
    logic [4:0] ex_load;
    logic [2:0] ex_store;
    logic id_hold;
    logic [31:0] bubble_count;

    int tests = 0;
    int fails = 0;
    vec_t  vt[$];
    snap_t sb[$];
    snap_t dut_snap;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_jump(id_jump),
        .id_result_src(id_result_src), .id_alu_control(id_alu_control),
        .id_branch(id_branch), .id_load(id_load), .id_store(id_store),
        .ex_stall(ex_stall), .ex_flush(ex_flush), .ex_valid(ex_valid),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_jump(ex_jump),
        .ex_result_src(ex_result_src), .ex_alu_control(ex_alu_control),
        .ex_branch(ex_branch), .ex_load(ex_load), .ex_store(ex_store),
        .id_hold(id_hold), .bubble_count(bubble_count)
    );

    always_comb begin
        dut_snap        = '0;
        dut_snap.valid  = ex_valid;
        dut_snap.rs1    = ex_rs1;
        dut_snap.rs2    = ex_rs2;
        dut_snap.rd     = ex_rd;
        dut_snap.pc     = ex_pc;
        dut_snap.pc4    = ex_pc_plus4;
        dut_snap.rd1    = ex_rd1;
        dut_snap.rd2    = ex_rd2;
        dut_snap.imm    = ex_imm;
        dut_snap.regw   = ex_reg_write;
        dut_snap.memw   = ex_mem_write;
        dut_snap.alusrc = ex_alu_src;
        dut_snap.jump   = ex_jump;
        dut_snap.rsrc   = ex_result_src;
        dut_snap.aluc   = ex_alu_control;
        dut_snap.br     = ex_branch;
        dut_snap.ld     = ex_load;
        dut_snap.st     = ex_store;
        dut_snap.cnt    = bubble_count;
    end

    function automatic logic [5:0] br_of(input logic [7:0] t);
        logic [5:0] one = 6'b000001;
        return t[7] ? 6'b101010 : (one << (t % 6));
    endfunction

    function automatic logic [2:0] st_of(input logic [7:0] t);
        logic [2:0] one = 3'b001;
        return one << (t % 3);
    endfunction

    function automatic vec_t mk(input logic v, input logic [6:0] op, input logic [4:0] rs1, rs2, rd,
                                input logic regw, input logic [4:0] ld, input logic [7:0] tag,
                                input logic stall, flush, hold, input kind_e kind);
        vec_t r;
        r.v = v; r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.regw = regw; r.ld = ld;
        r.tag = tag; r.stall = stall; r.flush = flush; r.exp_hold = hold; r.kind = kind;
        return r;
    endfunction

    task automatic drive(input vec_t c);
        id_valid       = c.v;
        id_op          = c.op;
        id_rs1         = c.rs1;
        id_rs2         = c.rs2;
        id_rd          = c.rd;
        id_pc          = 32'h1000_0000 | {22'd0, c.tag, 2'b00};
        id_pc_plus4    = (32'h1000_0000 | {22'd0, c.tag, 2'b00}) + 32'd4;
        id_rd1         = 32'hA000_0000 | {24'd0, c.tag};
        id_rd2         = 32'hB000_0000 | {24'd0, c.tag};
        id_imm         = 32'hC000_0000 | {24'd0, c.tag};
        id_reg_write   = c.regw;
        id_mem_write   = c.tag[0];
        id_alu_src     = c.tag[1];
        id_jump        = c.tag[2];
        id_result_src  = c.tag[4:3];
        id_alu_control = c.tag[3:0];
        id_branch      = br_of(c.tag);
        id_load        = c.ld;
        id_store       = st_of(c.tag);
        ex_stall       = c.stall;
        ex_flush       = c.flush;
    endtask

    function automatic snap_t captured(input vec_t c, input logic [31:0] cnt);
        snap_t s = '0;
        s.valid = c.v;
        s.rs1   = c.rs1;
        s.rs2   = c.rs2;
        s.rd    = c.rd;
        s.pc    = 32'h1000_0000 | {22'd0, c.tag, 2'b00};
        s.pc4   = s.pc + 32'd4;
        s.rd1   = 32'hA000_0000 | {24'd0, c.tag};
        s.rd2   = 32'hB000_0000 | {24'd0, c.tag};
        s.imm   = 32'hC000_0000 | {24'd0, c.tag};
        if (c.v) begin
            s.regw   = c.regw;
            s.memw   = c.tag[0];
            s.alusrc = c.tag[1];
            s.jump   = c.tag[2];
            s.rsrc   = c.tag[4:3];
            s.aluc   = c.tag[3:0];
            s.br     = br_of(c.tag);
            s.ld     = c.ld;
            s.st     = st_of(c.tag);
        end
        s.cnt = cnt;
        return s;
    endfunction

    task automatic chk_snap(input string name, input snap_t act, input snap_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        snap_t       last;
        snap_t       e;
        logic [31:0] cnt;
        vec_t        idle;

        idle = mk(0, 7'd0, 0, 0, 0, 0, 5'd0, 8'd0, 0, 0, 0, K_CAP);
        rst = 1'b1;
        drive(idle);
        #2;
        chk_snap("reset_state", dut_snap, '0);
        chk_bit("reset_hold", id_hold, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        vt.push_back(mk(1, OP_R,     1, 2, 3, 1, 5'd0, 8'd1,  0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LOAD,  4, 0, 5, 1, LW,   8'd2,  0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_R,     5, 1, 6, 1, 5'd0, 8'd3,  0, 0, 1, K_LUB));
        vt.push_back(mk(1, OP_R,     5, 1, 6, 1, 5'd0, 8'd3,  0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LOAD,  4, 0, 0, 1, LW,   8'd4,  0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_R,     0, 0, 7, 1, 5'd0, 8'd5,  0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LOAD,  4, 0, 5, 1, LW,   8'd6,  0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LUI,   5, 5, 5, 1, 5'd0, 8'd7,  0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LOAD,  4, 0, 5, 1, LW,   8'd8,  0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_I,     4, 5, 7, 1, 5'd0, 8'd9,  0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LOAD,  4, 0, 5, 1, LW,   8'd10, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_STORE, 2, 5, 0, 0, 5'd0, 8'd11, 0, 0, 1, K_LUB));
        vt.push_back(mk(1, OP_STORE, 2, 5, 0, 0, 5'd0, 8'd11, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LOAD,  1, 0, 9, 1, LB,   8'd12, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_R,     9, 9, 10, 1, 5'd0, 8'd13, 0, 1, 0, K_BUB));
        vt.push_back(mk(1, OP_R,     9, 9, 10, 1, 5'd0, 8'd13, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_R,     1, 2, 11, 1, 5'd0, 8'd14, 1, 0, 1, K_HOLD));
        vt.push_back(mk(1, OP_R,     1, 2, 12, 1, 5'd0, 8'd15, 1, 0, 1, K_HOLD));
        vt.push_back(mk(1, OP_R,     1, 2, 13, 1, 5'd0, 8'd16, 1, 0, 1, K_HOLD));
        vt.push_back(mk(1, OP_R,     1, 2, 14, 1, 5'd0, 8'd17, 1, 1, 1, K_BUB));
        vt.push_back(mk(0, OP_R,     5, 5, 12, 1, LW,   8'h90, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_R,     1, 2, 3, 1, 5'd0, 8'h85, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LOAD,  1, 0, 5, 1, LW,   8'd22, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_R,     5, 1, 6, 1, 5'd0, 8'd23, 0, 0, 1, K_LUB));
        vt.push_back(mk(1, OP_R,     5, 1, 6, 1, 5'd0, 8'd23, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_R,     5, 2, 7, 1, 5'd0, 8'd24, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LOAD,  1, 0, 5, 1, LHU,  8'd25, 0, 0, 0, K_CAP));
        vt.push_back(mk(0, OP_R,     5, 5, 8, 1, 5'd0, 8'd26, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_LOAD,  1, 0, 5, 1, LW,   8'd27, 0, 0, 0, K_CAP));
        vt.push_back(mk(1, OP_R,     5, 1, 6, 1, 5'd0, 8'd28, 1, 0, 1, K_HOLD));
        vt.push_back(mk(1, OP_R,     5, 1, 6, 1, 5'd0, 8'd28, 0, 0, 1, K_LUB));
        vt.push_back(mk(1, OP_R,     5, 1, 6, 1, 5'd0, 8'd28, 0, 0, 0, K_CAP));

        cnt  = 32'd0;
        last = '0;
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            chk_bit($sformatf("hold_row%0d", i), id_hold, vt[i].exp_hold);
            case (vt[i].kind)
                K_CAP:   e = captured(vt[i], cnt);
                K_HOLD:  e = last;
                K_LUB:   begin cnt = cnt + 32'd1; e = '0; e.cnt = cnt; end
                default: begin e = '0; e.cnt = cnt; end
            endcase
            last = e;
            sb.push_back(e);
            @(posedge clk);
            #1;
            chk_snap($sformatf("ex_row%0d", i), dut_snap, sb.pop_front());
        end

        // asynchronous reset in the middle of a stall, away from any clock edge
        @(negedge clk);
        drive(mk(1, OP_LOAD, 1, 0, 5, 1, LW, 8'd40, 0, 0, 0, K_CAP));
        @(posedge clk);
        #1;
        chk_bit("pre_reset_valid", ex_valid, 1'b1);
        ex_stall = 1'b1;
        id_rs1 = 5'd5;
        id_op = OP_R;
        id_load = 5'd0;
        #1;
        rst = 1'b1;
        #1;
        chk_snap("mid_stall_reset", dut_snap, '0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, OP_R, 1, 2, 3, 1, 5'd0, 8'd41, 0, 0, 0, K_CAP));
        sb.push_back(captured(mk(1, OP_R, 1, 2, 3, 1, 5'd0, 8'd41, 0, 0, 0, K_CAP), 32'd0));
        @(posedge clk);
        #1;
        chk_snap("post_reset_capture", dut_snap, sb.pop_front());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
